// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU ctrl codes, sequencer states, slice op codes and ctrl decode
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  // Slice controls plus how the sequencer must finish the result.
  typedef struct packed {
    logic       valid;  // ctrl code recognised
    logic       arith;  // ADD/SUB/SLT: cout and overflow are meaningful
    logic       slt;    // final result is the signed less-than bit
    logic       a_inv;
    logic       b_inv;
    logic [1:0] op;
  } dec_t;

  function automatic dec_t decode_ctrl(input logic [3:0] ctrl);
    dec_t d;
    d = '0;
    d.op = OP_AND;
    case (ctrl)
      CTRL_AND: begin d.valid = 1'b1; d.op = OP_AND; end
      CTRL_OR:  begin d.valid = 1'b1; d.op = OP_OR; end
      CTRL_ADD: begin d.valid = 1'b1; d.arith = 1'b1; d.op = OP_ADD; end
      CTRL_SUB: begin d.valid = 1'b1; d.arith = 1'b1; d.b_inv = 1'b1; d.op = OP_ADD; end
      CTRL_SLT: begin
        d.valid = 1'b1; d.arith = 1'b1; d.slt = 1'b1; d.b_inv = 1'b1; d.op = OP_ADD;
      end
      CTRL_NOR: begin d.valid = 1'b1; d.a_inv = 1'b1; d.b_inv = 1'b1; d.op = OP_AND; end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - 1-bit combinational ALU slice (invert, AND/OR/sum/less, carry out)
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       less_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic       cin_i,
  input  logic [1:0] op_i,
  output logic       result_o,
  output logic       cout_o
);

  logic a_eff;
  logic b_eff;
  logic sum;

  // Optional operand inversion, full adder, and result select.
  always_comb begin
    a_eff  = a_i ^ a_invert_i;
    b_eff  = b_i ^ b_invert_i;
    sum    = a_eff ^ b_eff ^ cin_i;
    cout_o = (a_eff & b_eff) | (a_eff & cin_i) | (b_eff & cin_i);
    case (op_i)
      OP_AND:  result_o = a_eff & b_eff;
      OP_OR:   result_o = a_eff | b_eff;
      OP_ADD:  result_o = sum;
      default: result_o = less_i;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU sequencer; optional abort_i via ALU_SERIAL_ABORT_EN
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] res_q;     // bits already produced, newest at the top
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  dec_t             dec_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;

  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] shift_cat;
  logic [WIDTH-1:0] result_d;
  logic             cout_d;
  logic             ovf_d;
  logic             abort;
  logic             accept;
  dec_t             dec_in;

  alu_bit_slice u_slice (
    .a_i        (a_q[0]),
    .b_i        (b_q[0]),
    .less_i     (1'b0),
    .a_invert_i (dec_q.a_inv),
    .b_invert_i (dec_q.b_inv),
    .cin_i      (carry_q),
    .op_i       (dec_q.op),
    .result_o   (slice_res),
    .cout_o     (slice_cout)
  );

`ifdef ALU_SERIAL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign accept = in_valid_i & in_ready_q;
  assign dec_in = decode_ctrl(ctrl_i);

  // Final result and flags as they would be captured on the edge that processes the MSB.
  always_comb begin
    shift_cat = {slice_res, res_q};
    result_d  = '0;
    cout_d    = 1'b0;
    ovf_d     = 1'b0;
    if (dec_q.valid) begin
      if (dec_q.arith) begin
        cout_d = slice_cout;
        ovf_d  = carry_q ^ slice_cout;
      end
      if (dec_q.slt) begin
        result_d = {{(WIDTH-1){1'b0}}, slice_res ^ (carry_q ^ slice_cout)};
      end else begin
        result_d = shift_cat;
      end
    end
  end

  // Sequencer FSM: accept, shift one bit per cycle, then hold the result until taken.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      dec_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_RUN;
            a_q        <= src1_i;
            b_q        <= src2_i;
            dec_q      <= dec_in;
            carry_q    <= dec_in.b_inv & dec_in.arith;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
          end else begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= shift_cat[WIDTH-1:1];
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_q     <= ST_DONE;
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
              result_q    <= result_d;
              zero_q      <= (result_d == '0);
              cout_q      <= cout_d;
              ovf_q       <= ovf_d;
            end
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign cout_o      = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed vector bench for alu_serial_seq; abort case under ALU_SERIAL_ABORT_EN
module tb_alu_serial_seq;

  localparam int W = 32;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    ctrl = 4'b0000;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          zero;
  logic          cout;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
`ifdef ALU_SERIAL_ABORT_EN
    .abort_i     (abort),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .ctrl_i      (ctrl),
    .src1_i      (src1),
    .src2_i      (src2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .zero_o      (zero),
    .cout_o      (cout),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge just after the accept edge; counts edges until out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  // Starts at a negedge; returns at a negedge with the DUT in DONE (or timed out).
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    int g;
    g = 0;
    while (!in_ready && g < BUDGET) begin
      @(negedge clk);
      g++;
    end
    ctrl = c; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl = 4'b0010; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
    @(negedge clk);
    wait_done(lat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;

    vecs[0]  = '{4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'd3,         32'd5,         32'hFFFFFFFE,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0110, 32'd5,         32'd5,         32'd0,         1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'b0010, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 1'b0, 1'b1};
    vecs[4]  = '{4'b0111, 32'h7FFFFFFF,  32'h80000000,  32'd0,         1'b1, 1'b0, 1'b1};
    vecs[5]  = '{4'b0111, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b1100, 32'd0,         32'd0,         32'hFFFFFFFF,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 32'hF0,        32'h0F,        32'hFF,        1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0000, 32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0010, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, 32'h12345678,  32'd9,         32'd0,         1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'b0010, 32'h80000000,  32'h80000000,  32'd0,         1'b1, 1'b1, 1'b1};
    vecs[12] = '{4'b0111, 32'd5,         32'd3,         32'd0,         1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(W));
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      handshake();
    end

    // Hold in DONE with out_ready low
    run_op(4'b0001, 32'hF0, 32'h0F, lat);
    chk("hold_latency", 32'(lat), 32'(W));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_result", i), result, 32'hFF);
    end

    // Back-to-back: new op offered during the output handshake
    ctrl = 4'b0010; src1 = 32'd5; src2 = 32'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_idle_ready", 32'(in_ready), 32'd1);
    chk("b2b_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1 = '0; src2 = '0;
    @(negedge clk);
    chk("b2b_run_ready", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("b2b_latency", 32'(lat), 32'(W));
    chk("b2b_result", result, 32'd12);
    handshake();

    // Reset at bit 10 of RUN
    run_op(4'b0010, 32'h7FFFFFFF, 32'd1, lat);
    chk("pre_rst_ovf", 32'(ovf), 32'd1);
    handshake();
    ctrl = 4'b0000; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'b0110, 32'd3, 32'd5, lat);
    chk("postrst_latency", 32'(lat), 32'(W));
    chk("postrst_result", result, 32'hFFFFFFFE);
    handshake();

`ifdef ALU_SERIAL_ABORT_EN
    // Abort at bit 5: back to IDLE, no out_valid, previous result kept
    held = result;
    ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", result, held);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < W + 5; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
    end
    run_op(4'b0010, 32'd5, 32'd7, lat);
    chk("postabort_result", result, 32'd12);
    handshake();
`else
    held = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
